// File: rtl/sync_updown_counter_pkg.sv
// Shared constants and Gray helper for the synchronous up/down counter.
// bin2gray is only referenced by the top when SYNC_CNT_GRAY_EN is defined.
package cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // 32-bit wide so any counter width up to 32 can share it; callers cast to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_updown_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
// The q_gray member exists only when SYNC_CNT_GRAY_EN is defined.
interface sync_updown_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
`ifdef SYNC_CNT_GRAY_EN
    logic [WIDTH-1:0] q_gray;

    modport master (output en, up_dn, load, load_val, input q, tc, wrap, q_gray);
    modport slave  (input en, up_dn, load, load_val, output q, tc, wrap, q_gray);
`else
    modport master (output en, up_dn, load, load_val, input q, tc, wrap);
    modport slave  (input en, up_dn, load, load_val, output q, tc, wrap);
`endif
endinterface

// File: rtl/sync_updown_counter_next.sv
// Combinational next-count and wrap detection for one enabled step in either direction.
module cnt_next
    import cnt_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_nxt
);

    localparam logic [WIDTH:0] TOP = (WIDTH + 1)'(MODULO - 1);

    logic at_top;
    logic at_zero;

    // Anything at or above MODULO-1 counts as the top value, so a stray q still wraps.
    assign at_top  = ({1'b0, q} >= TOP);
    assign at_zero = (q == '0);

    always_comb begin
        nxt      = q;
        wrap_nxt = 1'b0;
        case (up_dn)
            CNT_UP: begin
                if (at_top) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = WIDTH'({1'b0, q} + (WIDTH + 1)'(1));
                end
            end
            CNT_DN: begin
                if (at_zero) begin
                    nxt      = TOP[WIDTH-1:0];
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = WIDTH'({1'b0, q} - (WIDTH + 1)'(1));
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo up/down counter with load, terminal count and wrap pulse.
// Define SYNC_CNT_GRAY_EN to add a registered Gray-coded copy of the count.
module sync_updown_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULO  = 2 ** WIDTH,
    parameter int RST_VAL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    sync_updown_counter_if.slave   cnt_if
);

    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] TOP_Q   = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_val;
    logic             step_wrap;

    cnt_next #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) u_next (
        .q        (cnt_q),
        .up_dn    (cnt_if.up_dn),
        .nxt      (step_val),
        .wrap_nxt (step_wrap)
    );

    // Load takes precedence over counting; oversized load values saturate at the top.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (cnt_if.load) begin
            cnt_d = ({1'b0, cnt_if.load_val} < MOD_EXT) ? cnt_if.load_val : TOP_Q;
        end else if (cnt_if.en) begin
            cnt_d  = step_val;
            wrap_d = step_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RST_Q;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_if.q    = cnt_q;
    assign cnt_if.wrap = wrap_q;
    assign cnt_if.tc   = cnt_if.en & ~cnt_if.load & step_wrap;

`ifdef SYNC_CNT_GRAY_EN
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RST_VAL)));

    logic [WIDTH-1:0] gray_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= RST_GRAY;
        end else begin
            gray_q <= WIDTH'(bin2gray(32'(cnt_d)));
        end
    end

    assign cnt_if.q_gray = gray_q;
`endif

endmodule

// File: tb/tb_sync_updown_counter.sv
// Two counters (MODULO 10 with nonzero reset value, and full-range MODULO 16) driven in lockstep
// against an arithmetic reference; Gray checks are compiled in with SYNC_CNT_GRAY_EN.
module tb_sync_updown_counter;

    localparam int W     = 4;
    localparam int MOD_A = 10;
    localparam int RV_A  = 3;
    localparam int MOD_B = 16;
    localparam int RV_B  = 0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_updown_counter_if #(.WIDTH(W)) if_a ();
    sync_updown_counter_if #(.WIDTH(W)) if_b ();

    sync_updown_counter #(.WIDTH(W), .MODULO(MOD_A), .RST_VAL(RV_A)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .cnt_if (if_a)
    );

    sync_updown_counter #(.WIDTH(W), .MODULO(MOD_B), .RST_VAL(RV_B)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .cnt_if (if_b)
    );

    int total = 0;
    int bad   = 0;
    int n_cyc = 0;

    int ref_qa = 0;
    int ref_qb = 0;
`ifdef SYNC_CNT_GRAY_EN
    int gray_prev_b = 0;
`endif

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, n_cyc, got, exp);
        end
    endtask

    function automatic int ref_tc(input int m, input int q, input bit l, input bit e, input bit u);
        if (!e || l) return 0;
        return u ? int'(q == m - 1) : int'(q == 0);
    endfunction

    // Behavioural next state: plain modular arithmetic over the range 0..m-1.
    task automatic ref_step(input int m, input int rv, input int q_in,
                            input bit r, input bit l, input int lv, input bit e, input bit u,
                            output int q_out, output int w_out);
        w_out = 0;
        q_out = q_in;
        if (r) begin
            q_out = rv;
        end else if (l) begin
            q_out = (lv < m) ? lv : m - 1;
        end else if (e) begin
            int raw;
            raw   = q_in + (u ? 1 : -1);
            q_out = (raw + m) % m;
            w_out = (raw < 0 || raw >= m) ? 1 : 0;
        end
    endtask

    task automatic cyc(input bit r, input bit l, input int lv, input bit e, input bit u);
        int nqa, nwa, nqb, nwb;
        rst           = r;
        if_a.load     = l;  if_b.load     = l;
        if_a.load_val = W'(lv);
        if_b.load_val = W'(lv);
        if_a.en       = e;  if_b.en       = e;
        if_a.up_dn    = u;  if_b.up_dn    = u;
        @(negedge clk);
        chk("tc_a", 32'(if_a.tc), ref_tc(MOD_A, ref_qa, l, e, u));
        chk("tc_b", 32'(if_b.tc), ref_tc(MOD_B, ref_qb, l, e, u));
        ref_step(MOD_A, RV_A, ref_qa, r, l, lv, e, u, nqa, nwa);
        ref_step(MOD_B, RV_B, ref_qb, r, l, lv, e, u, nqb, nwb);
        @(posedge clk);
        #1;
        n_cyc++;
        chk("q_a", 32'(if_a.q), nqa);
        chk("wrap_a", 32'(if_a.wrap), nwa);
        chk("q_b", 32'(if_b.q), nqb);
        chk("wrap_b", 32'(if_b.wrap), nwb);
`ifdef SYNC_CNT_GRAY_EN
        chk("gray_a", 32'(if_a.q_gray), nqa ^ (nqa >> 1));
        chk("gray_b", 32'(if_b.q_gray), nqb ^ (nqb >> 1));
        if (!r && !l && e)
            chk("gray_ham_b", $countones(32'(if_b.q_gray) ^ gray_prev_b), 1);
        gray_prev_b = 32'(if_b.q_gray);
`endif
        ref_qa = nqa;
        ref_qb = nqb;
        $display("cyc %0d rst=%0b ld=%0b lv=%0d en=%0b up=%0b | qa=%0d wa=%0b qb=%0d wb=%0b",
                 n_cyc, r, l, lv, e, u, if_a.q, if_a.wrap, if_b.q, if_b.wrap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", n_cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset overrides simultaneous load and enable.
        cyc(1, 1, 12, 1, 1);
        cyc(1, 1, 12, 1, 1);
        chk("rst_q_a", 32'(if_a.q), RV_A);
        chk("rst_wrap_a", 32'(if_a.wrap), 0);

        // Up from 0 through the MODULO-10 wrap.
        cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 1);

        // Down from 0 wraps to the top, then holds with enable low.
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

        // Load beats count; oversize load saturates.
        cyc(0, 1, 7, 1, 1);
        cyc(0, 1, 15, 1, 0);

        // Reset mid-count, then resume.
        cyc(0, 1, 5, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);

        // Full cycle of the 16-state counter, including 15 -> 0, then back down through 0.
        cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

        for (int i = 0; i < 250; i++) begin
            bit r, l, e, u;
            int lv;
            r  = ($urandom_range(0, 31) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1) == 1;
            lv = int'($urandom_range(0, 15));
            cyc(r, l, lv, e, u);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
